// File: rtl/pc_unit.sv
// Program counter with boot, run and trap modes: sequential fetch, branch redirect,
// misaligned-target trapping and single-level trap entry/return with a saved epc.
module pc_unit #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             trap_req,
   input  logic             trap_ret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             pc_valid,
   output logic [WIDTH-1:0] epc,
   output logic             in_trap,
   output logic             misalign_err
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] epc_nxt;
   logic             err_nxt;
   logic             misaligned;

   assign pc_plus4   = pc + WIDTH'(4);
   assign misaligned = (redirect_pc[1:0] != 2'b00);
   assign pc_valid   = (state != BOOT);
   assign in_trap    = (state == TRAP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= BOOT;
         pc           <= RESET_VECTOR;
         epc          <= '0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         epc          <= epc_nxt;
         misalign_err <= err_nxt;
      end
   end

   // A misaligned redirect behaves like a trap; in TRAP it re-vectors without touching epc.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      epc_nxt   = epc;
      err_nxt   = 1'b0;
      case (state)
         BOOT: begin
            state_nxt = RUN;
         end
         RUN: begin
            if (trap_req) begin
               pc_nxt    = TRAP_VECTOR;
               epc_nxt   = pc;
               state_nxt = TRAP;
            end else if (redirect_valid && misaligned) begin
               pc_nxt    = TRAP_VECTOR;
               epc_nxt   = pc;
               state_nxt = TRAP;
               err_nxt   = 1'b1;
            end else if (redirect_valid) begin
               pc_nxt = redirect_pc;
            end else if (!stall) begin
               pc_nxt = pc_plus4;
            end
         end
         TRAP: begin
            if (trap_ret) begin
               pc_nxt    = epc;
               state_nxt = RUN;
            end else if (redirect_valid && misaligned) begin
               pc_nxt  = TRAP_VECTOR;
               err_nxt = 1'b1;
            end else if (redirect_valid) begin
               pc_nxt = redirect_pc;
            end else if (!stall) begin
               pc_nxt = pc_plus4;
            end
         end
         default: begin
            state_nxt = BOOT;
            pc_nxt    = RESET_VECTOR;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand-written reset/width sequences and a
// randomized run checked against a rule-level reference model.
module tb_pc_unit;

   localparam logic [31:0] TV = 32'h0000_0100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, redirect_valid, trap_req, trap_ret;
   logic [31:0] redirect_pc;
   logic [31:0] pc, pc_plus4, epc;
   logic        pc_valid, in_trap, misalign_err;

   logic        rst8, z1;
   logic [7:0]  z8;
   logic [7:0]  pc8, pc_plus4_8, epc8;
   logic        pc_valid8, in_trap8, err8;

   int n_cmp = 0;
   int n_err = 0;

   pc_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .trap_req(trap_req), .trap_ret(trap_ret),
      .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid), .epc(epc),
      .in_trap(in_trap), .misalign_err(misalign_err)
   );

   pc_unit #(.WIDTH(8), .RESET_VECTOR(8'hF8)) dut8 (
      .clk(clk), .rst(rst8), .stall(z1), .redirect_valid(z1),
      .redirect_pc(z8), .trap_req(z1), .trap_ret(z1),
      .pc(pc8), .pc_plus4(pc_plus4_8), .pc_valid(pc_valid8), .epc(epc8),
      .in_trap(in_trap8), .misalign_err(err8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                            input logic e_valid, input logic e_trap, input logic e_err);
      check($sformatf("%s.pc", tag), pc, e_pc);
      check($sformatf("%s.pc_plus4", tag), pc_plus4, e_pc + 32'd4);
      check($sformatf("%s.epc", tag), epc, e_epc);
      check($sformatf("%s.pc_valid", tag), {31'd0, pc_valid}, {31'd0, e_valid});
      check($sformatf("%s.in_trap", tag), {31'd0, in_trap}, {31'd0, e_trap});
      check($sformatf("%s.misalign_err", tag), {31'd0, misalign_err}, {31'd0, e_err});
   endtask

   task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                        input logic tq, input logic tr);
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      trap_req       = tq;
      trap_ret       = tr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed vectors: inputs applied before an edge, expected outputs after it.
   typedef struct {
      logic        st, rv;
      logic [31:0] rpc;
      logic        tq, tr;
      logic [31:0] e_pc, e_epc;
      logic        e_trap, e_err;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input logic st, input logic rv, input logic [31:0] rpc,
                               input logic tq, input logic tr, input logic [31:0] e_pc,
                               input logic [31:0] e_epc, input logic e_trap, input logic e_err);
      vec_t v;
      v.st = st; v.rv = rv; v.rpc = rpc; v.tq = tq; v.tr = tr;
      v.e_pc = e_pc; v.e_epc = e_epc; v.e_trap = e_trap; v.e_err = e_err;
      vecs.push_back(v);
   endfunction

   // Reference model: 0 = boot, 1 = run, 2 = trap.
   int          m_mode;
   logic [31:0] m_pc, m_epc;
   logic        m_err;

   task automatic model_reset();
      m_mode = 0; m_pc = 32'd0; m_epc = 32'd0; m_err = 1'b0;
   endtask

   task automatic model_step();
      logic mis;
      mis   = (redirect_pc % 4) != 0;
      m_err = 1'b0;
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (trap_req || (redirect_valid && mis)) begin
            m_err  = !trap_req;
            m_epc  = m_pc;
            m_pc   = TV;
            m_mode = 2;
         end else if (redirect_valid) m_pc = redirect_pc;
         else if (!stall) m_pc = m_pc + 32'd4;
      end else begin
         if (trap_ret) begin
            m_pc   = m_epc;
            m_mode = 1;
         end else if (redirect_valid && mis) begin
            m_pc  = TV;
            m_err = 1'b1;
         end else if (redirect_valid) m_pc = redirect_pc;
         else if (!stall) m_pc = m_pc + 32'd4;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rpc;
      rst = 1'b0; rst8 = 1'b0; z1 = 1'b0; z8 = 8'd0;
      drive(0, 0, 32'd0, 0, 0);
      repeat (2) tick();
      check_all("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

      // 8-bit instance: boot at F8 then wrap through zero.
      rst8 = 1'b1;
      check("w8.boot_pc", {24'd0, pc8}, 32'h0000_00F8);
      check("w8.boot_valid", {31'd0, pc_valid8}, 32'd0);
      tick();
      check("w8.pc0", {24'd0, pc8}, 32'h0000_00F8);
      check("w8.valid", {31'd0, pc_valid8}, 32'd1);
      tick();
      check("w8.pc1", {24'd0, pc8}, 32'h0000_00FC);
      check("w8.plus4_wrap", {24'd0, pc_plus4_8}, 32'd0);
      tick();
      check("w8.pc2", {24'd0, pc8}, 32'd0);
      tick();
      check("w8.pc3", {24'd0, pc8}, 32'd4);

      // Main directed table.
      add(0,0,32'h0,0,0, 32'h0,  32'h0, 0,0);
      add(0,0,32'h0,0,0, 32'h4,  32'h0, 0,0);
      add(0,0,32'h0,0,0, 32'h8,  32'h0, 0,0);
      add(0,0,32'h0,0,0, 32'hC,  32'h0, 0,0);
      add(0,0,32'h0,0,0, 32'h10, 32'h0, 0,0);
      add(0,1,32'h22,0,0, TV,    32'h10, 1,1);
      add(0,0,32'h0,0,0, 32'h104,32'h10, 1,0);
      add(0,0,32'h0,0,1, 32'h10, 32'h10, 0,0);
      add(0,0,32'h0,0,0, 32'h14, 32'h10, 0,0);
      add(0,0,32'h0,0,0, 32'h18, 32'h10, 0,0);
      add(0,0,32'h0,0,0, 32'h1C, 32'h10, 0,0);
      add(0,0,32'h0,0,0, 32'h20, 32'h10, 0,0);
      add(1,0,32'h0,0,0, 32'h20, 32'h10, 0,0);
      add(1,0,32'h0,0,0, 32'h20, 32'h10, 0,0);
      add(1,0,32'h0,0,0, 32'h20, 32'h10, 0,0);
      add(1,1,32'h80,0,0, 32'h80, 32'h10, 0,0);
      add(0,0,32'h0,0,0, 32'h84, 32'h10, 0,0);
      add(0,1,32'h40,0,0, 32'h40, 32'h10, 0,0);
      add(0,1,32'h80,1,0, TV,     32'h40, 1,0);
      add(0,0,32'h0,0,0, 32'h104, 32'h40, 1,0);
      add(0,0,32'h0,1,0, 32'h108, 32'h40, 1,0);
      add(0,0,32'h0,0,1, 32'h40,  32'h40, 0,0);
      add(0,0,32'h0,1,0, TV,      32'h40, 1,0);
      add(0,1,32'h33,0,0, TV,     32'h40, 1,1);
      add(0,1,32'h200,0,0, 32'h200, 32'h40, 1,0);
      add(1,0,32'h0,0,0, 32'h200, 32'h40, 1,0);
      add(1,0,32'h0,0,1, 32'h40,  32'h40, 0,0);
      add(0,0,32'h0,0,1, 32'h44,  32'h40, 0,0);
      add(1,1,32'h4A,0,0, TV,     32'h44, 1,1);
      add(0,0,32'h0,0,1, 32'h44,  32'h44, 0,0);
      add(0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 32'h44, 0,0);
      add(0,0,32'h0,0,0, 32'h0,   32'h44, 0,0);
      add(0,0,32'h0,0,0, 32'h4,   32'h44, 0,0);

      rst = 1'b1;
      check("boot.valid", {31'd0, pc_valid}, 32'd0);
      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].tq, vecs[i].tr);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_epc, 1'b1,
                   vecs[i].e_trap, vecs[i].e_err);
      end

      // Async reset pulse between edges while in TRAP with the error pulse high.
      drive(1, 1, 32'h6, 0, 0);
      tick();
      check_all("pre_rst", TV, 32'h4, 1'b1, 1'b1, 1'b1);
      #2 rst = 1'b0;
      #1 check_all("async_rst", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      drive(1, 1, 32'h3, 1, 0);
      tick();
      check_all("post_boot", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      drive(0, 0, 32'd0, 0, 0);
      tick();
      check_all("post_boot_inc", 32'h4, 32'd0, 1'b1, 1'b0, 1'b0);

      // Randomized run against the model, with occasional mid-cycle resets.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 600; i++) begin
         rpc = $urandom;
         if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | rpc[3:0];
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, rpc,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 2);
         tick();
         model_step();
         check_all($sformatf("rand%0d", i), m_pc, m_epc, m_mode != 0, m_mode == 2, m_err);
         if ($urandom_range(0, 49) == 0) begin
            #2 rst = 1'b0;
            model_reset();
            #1 check_all($sformatf("rand_rst%0d", i), m_pc, m_epc, 1'b0, 1'b0, 1'b0);
            #1 rst = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
